// File: rtl/eth_ipv4_multi_port_regs.sv
// Register file for NUM_PORTS Ethernet/IPv4/UDP transport adapters: address-decoded
// per-port pages holding addressing, pause, drop-counter and RX KV-map configuration.

module eth_ipv4_port_regs #(
    parameter int PORT_IDX         = 0,
    parameter int NUM_PORTS        = 2,
    parameter int CNT_W            = 32,
    parameter int PAUSE_EN         = 1,
    parameter int EN_RX_KV_MAP_CFG = 1
) (
    input  logic        bus_clk,
    input  logic        bus_rst_n,
    input  logic        wr_en,
    input  logic [3:0]  wr_idx,
    input  logic [31:0] wr_data,
    input  logic        rd_en,
    input  logic [3:0]  rd_idx,
    output logic [31:0] rd_data,
    output logic [47:0] my_mac,
    output logic [31:0] my_ip,
    output logic [15:0] my_udp_port,
    output logic [15:0] pause_set,
    output logic [15:0] pause_clear,
    input  logic        chdr_drop_evt,
    input  logic        cpu_drop_evt,
    output logic        kv_stb,
    input  logic        kv_busy,
    output logic [47:0] kv_mac_addr,
    output logic [31:0] kv_ip_addr,
    output logic [15:0] kv_udp_port,
    output logic [15:0] kv_dst_epid,
    output logic        kv_raw_udp
);
    localparam logic [3:0] R_MAC_LO = 4'd0,  R_MAC_HI = 4'd1,  R_IP = 4'd2,     R_UDP = 4'd3;
    localparam logic [3:0] R_PAUSE  = 4'd4,  R_CHDR   = 4'd5,  R_CPU = 4'd6,    R_KV_MAC_LO = 4'd7;
    localparam logic [3:0] R_KV_MAC_HI = 4'd8, R_KV_IP = 4'd9, R_KV_UDP = 4'd10, R_KV_CFG = 4'd11;
    localparam logic [3:0] R_INFO   = 4'd12;

    localparam logic       HAS_PAUSE = (PAUSE_EN != 0);
    localparam logic       HAS_KV    = (EN_RX_KV_MAP_CFG != 0);
    localparam logic [47:0] MAC_RST  = 48'h00802f16c52f + 48'(PORT_IDX);
    localparam logic [31:0] IP_RST   = 32'hc0a80a02 + 32'(PORT_IDX);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {KV_IDLE, KV_PEND} kv_state_t;

    kv_state_t        kv_state, kv_state_nxt;
    logic             kv_stb_q, kv_stb_nxt;
    logic             wr_kv_cfg, kv_data_we;
    logic [CNT_W-1:0] chdr_cnt, cpu_cnt;

    assign wr_kv_cfg  = wr_en && (wr_idx == R_KV_CFG) && HAS_KV;
    // KV entry fields are frozen while a load is pending so the adapter sees a stable entry
    assign kv_data_we = wr_en && HAS_KV && (kv_state == KV_IDLE);
    assign kv_stb     = kv_stb_q & HAS_KV;

    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            my_mac      <= MAC_RST;
            my_ip       <= IP_RST;
            my_udp_port <= 16'd49153;
            pause_set   <= 16'd40;
            pause_clear <= 16'd20;
            kv_mac_addr <= '0;
            kv_ip_addr  <= '0;
            kv_udp_port <= '0;
            kv_dst_epid <= '0;
            kv_raw_udp  <= 1'b0;
        end else if (wr_en) begin
            case (wr_idx)
                R_MAC_LO:    my_mac[31:0]  <= wr_data;
                R_MAC_HI:    my_mac[47:32] <= wr_data[15:0];
                R_IP:        my_ip         <= wr_data;
                R_UDP:       my_udp_port   <= wr_data[15:0];
                R_PAUSE: if (HAS_PAUSE) begin
                    pause_clear <= wr_data[31:16];
                    pause_set   <= wr_data[15:0];
                end
                R_KV_MAC_LO: if (kv_data_we) kv_mac_addr[31:0]  <= wr_data;
                R_KV_MAC_HI: if (kv_data_we) kv_mac_addr[47:32] <= wr_data[15:0];
                R_KV_IP:     if (kv_data_we) kv_ip_addr         <= wr_data;
                R_KV_UDP:    if (kv_data_we) kv_udp_port        <= wr_data[15:0];
                R_KV_CFG: if (HAS_KV) begin
                    kv_dst_epid <= wr_data[15:0];
                    kv_raw_udp  <= wr_data[16];
                end
                default: ;
            endcase
        end
    end

    // Clear-on-read: an event landing in the clearing cycle is kept as a count of one
    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            chdr_cnt <= '0;
            cpu_cnt  <= '0;
        end else begin
            if (rd_en && (rd_idx == R_CHDR))
                chdr_cnt <= CNT_W'(chdr_drop_evt);
            else if (chdr_drop_evt && (chdr_cnt != CNT_MAX))
                chdr_cnt <= chdr_cnt + CNT_ONE;
            if (rd_en && (rd_idx == R_CPU))
                cpu_cnt <= CNT_W'(cpu_drop_evt);
            else if (cpu_drop_evt && (cpu_cnt != CNT_MAX))
                cpu_cnt <= cpu_cnt + CNT_ONE;
        end
    end

    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            kv_state <= KV_IDLE;
            kv_stb_q <= 1'b0;
        end else begin
            kv_state <= kv_state_nxt;
            kv_stb_q <= kv_stb_nxt;
        end
    end

    always_comb begin
        kv_state_nxt = kv_state;
        kv_stb_nxt   = 1'b0;
        case (kv_state)
            KV_IDLE: if (wr_kv_cfg) begin
                if (kv_busy) kv_state_nxt = KV_PEND;
                else         kv_stb_nxt   = 1'b1;
            end
            KV_PEND: if (!kv_busy) begin
                kv_state_nxt = KV_IDLE;
                kv_stb_nxt   = 1'b1;
            end
            default: kv_state_nxt = KV_IDLE;
        endcase
    end

    always_comb begin
        rd_data = '0;
        case (rd_idx)
            R_MAC_LO:    rd_data = my_mac[31:0];
            R_MAC_HI:    rd_data = {16'h0, my_mac[47:32]};
            R_IP:        rd_data = my_ip;
            R_UDP:       rd_data = {16'h0, my_udp_port};
            R_PAUSE:     if (HAS_PAUSE) rd_data = {pause_clear, pause_set};
            R_CHDR:      rd_data = 32'(chdr_cnt);
            R_CPU:       rd_data = 32'(cpu_cnt);
            R_KV_MAC_LO: if (HAS_KV) rd_data = kv_mac_addr[31:0];
            R_KV_MAC_HI: if (HAS_KV) rd_data = {16'h0, kv_mac_addr[47:32]};
            R_KV_IP:     if (HAS_KV) rd_data = kv_ip_addr;
            R_KV_UDP:    if (HAS_KV) rd_data = {16'h0, kv_udp_port};
            R_KV_CFG:    if (HAS_KV)
                rd_data = {kv_busy | (kv_state == KV_PEND), 14'h0, kv_raw_udp, kv_dst_epid};
            R_INFO:      rd_data = {16'h0, 8'(NUM_PORTS), 6'h0, HAS_PAUSE, HAS_KV};
            default:     rd_data = '0;
        endcase
    end
endmodule

module eth_ipv4_multi_port_regs #(
    parameter int NUM_PORTS        = 2,
    parameter int REG_AWIDTH       = 14,
    parameter int PORT_STRIDE_LOG2 = 8,
    parameter int CNT_W            = 32,
    parameter int PAUSE_EN         = 1,
    parameter int EN_RX_KV_MAP_CFG = 1
) (
    input  logic                    bus_clk,
    input  logic                    bus_rst_n,
    input  logic                    reg_wr_req,
    input  logic [REG_AWIDTH-1:0]   reg_wr_addr,
    input  logic [31:0]             reg_wr_data,
    input  logic                    reg_rd_req,
    input  logic [REG_AWIDTH-1:0]   reg_rd_addr,
    output logic                    reg_rd_resp,
    output logic [31:0]             reg_rd_data,
    output logic [48*NUM_PORTS-1:0] my_mac,
    output logic [32*NUM_PORTS-1:0] my_ip,
    output logic [16*NUM_PORTS-1:0] my_udp_port,
    output logic [16*NUM_PORTS-1:0] pause_set,
    output logic [16*NUM_PORTS-1:0] pause_clear,
    input  logic [NUM_PORTS-1:0]    chdr_drop_evt,
    input  logic [NUM_PORTS-1:0]    cpu_drop_evt,
    output logic [NUM_PORTS-1:0]    kv_stb,
    input  logic [NUM_PORTS-1:0]    kv_busy,
    output logic [48*NUM_PORTS-1:0] kv_mac_addr,
    output logic [32*NUM_PORTS-1:0] kv_ip_addr,
    output logic [16*NUM_PORTS-1:0] kv_udp_port,
    output logic [16*NUM_PORTS-1:0] kv_dst_epid,
    output logic [NUM_PORTS-1:0]    kv_raw_udp
);
    localparam int PORT_W = REG_AWIDTH - PORT_STRIDE_LOG2;
    localparam int OFF_W  = PORT_STRIDE_LOG2;

    logic [PORT_W-1:0]           wr_port, rd_port;
    logic [OFF_W-1:0]            wr_off, rd_off;
    logic                        wr_off_ok, rd_off_ok;
    logic [NUM_PORTS-1:0]        wr_sel, rd_sel;
    logic [NUM_PORTS-1:0][31:0]  port_rd_data;
    logic [31:0]                 rd_mux;

    assign {wr_port, wr_off} = reg_wr_addr;
    assign {rd_port, rd_off} = reg_rd_addr;
    // Defined offsets are the word-aligned addresses 0x00..0x30
    assign wr_off_ok = (wr_off[1:0] == 2'b00) && (wr_off[OFF_W-1:2] <= (OFF_W-2)'(12));
    assign rd_off_ok = (rd_off[1:0] == 2'b00) && (rd_off[OFF_W-1:2] <= (OFF_W-2)'(12));

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign wr_sel[p] = reg_wr_req && wr_off_ok && (wr_port == PORT_W'(p));
        assign rd_sel[p] = reg_rd_req && rd_off_ok && (rd_port == PORT_W'(p));

        eth_ipv4_port_regs #(
            .PORT_IDX         (p),
            .NUM_PORTS        (NUM_PORTS),
            .CNT_W            (CNT_W),
            .PAUSE_EN         (PAUSE_EN),
            .EN_RX_KV_MAP_CFG (EN_RX_KV_MAP_CFG)
        ) u_port (
            .bus_clk       (bus_clk),
            .bus_rst_n     (bus_rst_n),
            .wr_en         (wr_sel[p]),
            .wr_idx        (wr_off[5:2]),
            .wr_data       (reg_wr_data),
            .rd_en         (rd_sel[p]),
            .rd_idx        (rd_off[5:2]),
            .rd_data       (port_rd_data[p]),
            .my_mac        (my_mac[48*p +: 48]),
            .my_ip         (my_ip[32*p +: 32]),
            .my_udp_port   (my_udp_port[16*p +: 16]),
            .pause_set     (pause_set[16*p +: 16]),
            .pause_clear   (pause_clear[16*p +: 16]),
            .chdr_drop_evt (chdr_drop_evt[p]),
            .cpu_drop_evt  (cpu_drop_evt[p]),
            .kv_stb        (kv_stb[p]),
            .kv_busy       (kv_busy[p]),
            .kv_mac_addr   (kv_mac_addr[48*p +: 48]),
            .kv_ip_addr    (kv_ip_addr[32*p +: 32]),
            .kv_udp_port   (kv_udp_port[16*p +: 16]),
            .kv_dst_epid   (kv_dst_epid[16*p +: 16]),
            .kv_raw_udp    (kv_raw_udp[p])
        );
    end

    always_comb begin
        rd_mux = '0;
        for (int p = 0; p < NUM_PORTS; p++)
            if (rd_sel[p]) rd_mux = port_rd_data[p];
    end

    // Registered read path; the mux samples pre-write state, so a same-cycle write is not seen
    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            reg_rd_resp <= 1'b0;
            reg_rd_data <= '0;
        end else begin
            reg_rd_resp <= |rd_sel;
            if (|rd_sel) reg_rd_data <= rd_mux;
        end
    end
endmodule

// File: tb/tb_eth_ipv4_multi_port_regs.sv
// Directed plus randomized bench for eth_ipv4_multi_port_regs against an array-based register model.

module tb_eth_ipv4_multi_port_regs;
    localparam int NP = 2, AW = 14, SL = 8, CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic              bus_clk = 1'b0, bus_rst_n = 1'b0;
    logic              reg_wr_req = 1'b0, reg_rd_req = 1'b0;
    logic [AW-1:0]     reg_wr_addr = '0, reg_rd_addr = '0;
    logic [31:0]       reg_wr_data = '0;
    logic              reg_rd_resp;
    logic [31:0]       reg_rd_data;
    logic [48*NP-1:0]  my_mac, kv_mac_addr;
    logic [32*NP-1:0]  my_ip, kv_ip_addr;
    logic [16*NP-1:0]  my_udp_port, pause_set, pause_clear, kv_udp_port, kv_dst_epid;
    logic [NP-1:0]     chdr_drop_evt = '0, cpu_drop_evt = '0, kv_busy = '0;
    logic [NP-1:0]     kv_stb, kv_raw_udp;

    always #5 bus_clk = ~bus_clk;

    eth_ipv4_multi_port_regs #(
        .NUM_PORTS(NP), .REG_AWIDTH(AW), .PORT_STRIDE_LOG2(SL),
        .CNT_W(CW), .PAUSE_EN(1), .EN_RX_KV_MAP_CFG(1)
    ) dut (
        .bus_clk(bus_clk), .bus_rst_n(bus_rst_n),
        .reg_wr_req(reg_wr_req), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
        .reg_rd_req(reg_rd_req), .reg_rd_addr(reg_rd_addr),
        .reg_rd_resp(reg_rd_resp), .reg_rd_data(reg_rd_data),
        .my_mac(my_mac), .my_ip(my_ip), .my_udp_port(my_udp_port),
        .pause_set(pause_set), .pause_clear(pause_clear),
        .chdr_drop_evt(chdr_drop_evt), .cpu_drop_evt(cpu_drop_evt),
        .kv_stb(kv_stb), .kv_busy(kv_busy),
        .kv_mac_addr(kv_mac_addr), .kv_ip_addr(kv_ip_addr), .kv_udp_port(kv_udp_port),
        .kv_dst_epid(kv_dst_epid), .kv_raw_udp(kv_raw_udp)
    );

    // Reference model: one entry per port, counters as plain integers
    logic [47:0] m_mac[NP], m_kmac[NP];
    logic [31:0] m_ip[NP], m_kip[NP];
    logic [15:0] m_udp[NP], m_pset[NP], m_pclr[NP], m_kudp[NP], m_epid[NP];
    logic        m_raw[NP];
    bit          m_pend[NP];
    int          m_cnt[NP][2];
    bit          exp_resp;
    logic [31:0] exp_rdata = '0;
    logic [NP-1:0] exp_stb;
    int errors = 0, checks = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            m_mac[p]  = 48'h00802f16c52f + 48'(p);
            m_ip[p]   = 32'hc0a80a02 + 32'(p);
            m_udp[p]  = 16'd49153;
            m_pset[p] = 16'd40;
            m_pclr[p] = 16'd20;
            m_kmac[p] = '0; m_kip[p] = '0; m_kudp[p] = '0; m_epid[p] = '0; m_raw[p] = 1'b0;
            m_pend[p] = 1'b0;
            m_cnt[p][0] = 0; m_cnt[p][1] = 0;
        end
        exp_rdata = '0;
    endtask

    function automatic bit off_ok(int o);
        return (o % 4 == 0) && (o <= 'h30);
    endfunction

    function automatic logic [31:0] mread(int p, int o);
        case (o)
            'h00: return m_mac[p][31:0];
            'h04: return {16'h0, m_mac[p][47:32]};
            'h08: return m_ip[p];
            'h0c: return {16'h0, m_udp[p]};
            'h10: return {m_pclr[p], m_pset[p]};
            'h14: return 32'(m_cnt[p][0]);
            'h18: return 32'(m_cnt[p][1]);
            'h1c: return m_kmac[p][31:0];
            'h20: return {16'h0, m_kmac[p][47:32]};
            'h24: return m_kip[p];
            'h28: return {16'h0, m_kudp[p]};
            'h2c: return {kv_busy[p] | m_pend[p], 14'h0, m_raw[p], m_epid[p]};
            default: return {16'h0, 8'(NP), 8'h03};
        endcase
    endfunction

    // Advance model and DUT by one clock, then compare every observable output
    task automatic step();
        int rp, ro, wp, wo;
        bit rv, wv, pend_old;
        logic [48*NP-1:0] e_mac, e_kmac;
        logic [32*NP-1:0] e_ip, e_kip;
        logic [16*NP-1:0] e_udp, e_ps, e_pc, e_kudp, e_epid;
        logic [NP-1:0]    e_raw;
        exp_stb = '0;
        exp_resp = 1'b0;
        if (!bus_rst_n) begin
            model_reset();
        end else begin
            rp = int'(reg_rd_addr[AW-1:SL]); ro = int'(reg_rd_addr[SL-1:0]);
            wp = int'(reg_wr_addr[AW-1:SL]); wo = int'(reg_wr_addr[SL-1:0]);
            rv = reg_rd_req && rp < NP && off_ok(ro);
            wv = reg_wr_req && wp < NP && off_ok(wo);
            exp_resp = rv;
            if (rv) exp_rdata = mread(rp, ro);
            for (int p = 0; p < NP; p++) begin
                for (int k = 0; k < 2; k++) begin
                    int ev;
                    ev = (k == 0) ? int'(chdr_drop_evt[p]) : int'(cpu_drop_evt[p]);
                    if (rv && rp == p && ro == ('h14 + 4 * k)) m_cnt[p][k] = ev;
                    else if (m_cnt[p][k] + ev <= CMAX)     m_cnt[p][k] += ev;
                end
                pend_old = m_pend[p];
                if (pend_old && !kv_busy[p]) begin
                    exp_stb[p] = 1'b1;
                    m_pend[p] = 1'b0;
                end
                if (wv && wp == p) begin
                    case (wo)
                        'h00: m_mac[p][31:0]  = reg_wr_data;
                        'h04: m_mac[p][47:32] = reg_wr_data[15:0];
                        'h08: m_ip[p]         = reg_wr_data;
                        'h0c: m_udp[p]        = reg_wr_data[15:0];
                        'h10: begin m_pclr[p] = reg_wr_data[31:16]; m_pset[p] = reg_wr_data[15:0]; end
                        'h1c: if (!pend_old) m_kmac[p][31:0]  = reg_wr_data;
                        'h20: if (!pend_old) m_kmac[p][47:32] = reg_wr_data[15:0];
                        'h24: if (!pend_old) m_kip[p]  = reg_wr_data;
                        'h28: if (!pend_old) m_kudp[p] = reg_wr_data[15:0];
                        'h2c: begin
                            m_epid[p] = reg_wr_data[15:0];
                            m_raw[p]  = reg_wr_data[16];
                            if (!pend_old) begin
                                if (kv_busy[p]) m_pend[p] = 1'b1;
                                else            exp_stb[p] = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
        @(posedge bus_clk);
        #1;
        for (int p = 0; p < NP; p++) begin
            e_mac[48*p +: 48] = m_mac[p];   e_kmac[48*p +: 48] = m_kmac[p];
            e_ip[32*p +: 32]  = m_ip[p];    e_kip[32*p +: 32]  = m_kip[p];
            e_udp[16*p +: 16] = m_udp[p];   e_kudp[16*p +: 16] = m_kudp[p];
            e_ps[16*p +: 16]  = m_pset[p];  e_pc[16*p +: 16]   = m_pclr[p];
            e_epid[16*p +: 16] = m_epid[p]; e_raw[p]           = m_raw[p];
        end
        chk("rd_resp", 128'(reg_rd_resp), 128'(exp_resp));
        if (exp_resp) chk("rd_data", 128'(reg_rd_data), 128'(exp_rdata));
        chk("kv_stb", 128'(kv_stb), 128'(exp_stb));
        chk("my_mac", 128'(my_mac), 128'(e_mac));
        chk("my_ip", 128'(my_ip), 128'(e_ip));
        chk("my_udp_port", 128'(my_udp_port), 128'(e_udp));
        chk("pause", 128'({pause_clear, pause_set}), 128'({e_pc, e_ps}));
        chk("kv_entry", 128'({kv_raw_udp, kv_dst_epid, kv_udp_port}), 128'({e_raw, e_epid, e_kudp}));
        chk("kv_addr", 128'({kv_mac_addr, kv_ip_addr}), 128'({e_kmac, e_kip}));
    endtask

    task automatic idle();
        reg_rd_req = 1'b0; reg_wr_req = 1'b0;
        chdr_drop_evt = '0; cpu_drop_evt = '0;
    endtask

    task automatic set_rd(input int p, input int o);
        reg_rd_req = 1'b1; reg_rd_addr = AW'(p * 256 + o);
    endtask

    task automatic set_wr(input int p, input int o, input logic [31:0] d);
        reg_wr_req = 1'b1; reg_wr_addr = AW'(p * 256 + o); reg_wr_data = d;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        int p, o;
        p = ($urandom_range(0, 9) == 0) ? int'($urandom_range(2, 3)) : int'($urandom_range(0, 1));
        case ($urandom_range(0, 11))
            0:       o = 'h34;
            1:       o = int'($urandom_range(0, 12)) * 4 + 1;
            default: o = int'($urandom_range(0, 12)) * 4;
        endcase
        return AW'(p * 256 + o);
    endfunction

    initial begin
        model_reset();
        repeat (2) @(posedge bus_clk);
        #1;
        chk("reset_rd_resp", 128'(reg_rd_resp), 128'(0));
        chk("reset_rd_data", 128'(reg_rd_data), 128'(0));
        chk("reset_kv_stb", 128'(kv_stb), 128'(0));
        chk("reset_mac", 128'(my_mac), 128'({48'h00802f16c530, 48'h00802f16c52f}));
        chk("reset_ip", 128'(my_ip), 128'({32'hc0a80a03, 32'hc0a80a02}));
        bus_rst_n = 1'b1;

        // Port 1 reset addressing
        idle(); set_rd(1, 'h00); step();
        chk("t1_mac_lsb", 128'(reg_rd_data), 128'(32'h2f16c530));
        idle(); set_rd(1, 'h08); step();
        chk("t1_ip", 128'(reg_rd_data), 128'(32'hc0a80a03));
        idle(); step();

        // UDP write/readback; other port untouched
        set_wr(0, 'h0c, 32'h0000_1234); step();
        idle(); set_rd(0, 'h0c); step();
        chk("t2_udp", 128'(reg_rd_data), 128'(32'h1234));
        chk("t2_udp_p1", 128'(my_udp_port[31:16]), 128'(16'd49153));

        // Read and write the same register in one cycle returns the old value
        idle(); set_rd(0, 'h08); set_wr(0, 'h08, 32'hdead_beef); step();
        chk("same_cycle_old", 128'(reg_rd_data), 128'(32'hc0a80a02));

        // Drop counter with an event in the clearing read cycle
        idle();
        repeat (5) begin chdr_drop_evt = 2'b10; step(); end
        set_rd(1, 'h14); step();
        chk("t3_cnt_5", 128'(reg_rd_data), 128'(5));
        idle(); set_rd(1, 'h14); step();
        chk("t3_cnt_1", 128'(reg_rd_data), 128'(1));

        // Saturation at 2^CNT_W-1
        idle();
        repeat (20) begin cpu_drop_evt = 2'b01; step(); end
        idle(); set_rd(0, 'h18); step();
        chk("t4_sat", 128'(reg_rd_data), 128'(15));
        idle(); set_rd(0, 'h18); step();
        chk("t4_clr", 128'(reg_rd_data), 128'(0));

        // KV config held pending while the adapter is busy
        idle(); kv_busy = 2'b01; set_wr(0, 'h2c, 32'h0001_0042); step();
        chk("t5_no_stb", 128'(kv_stb), 128'(0));
        idle(); set_rd(0, 'h2c); step();
        chk("t5_busy_bit", 128'(reg_rd_data[31]), 128'(1));
        idle(); kv_busy = 2'b00; step();
        chk("t5_stb", 128'(kv_stb), 128'(2'b01));
        chk("t5_epid", 128'(kv_dst_epid[15:0]), 128'(16'h42));
        chk("t5_raw", 128'(kv_raw_udp[0]), 128'(1));
        step();
        chk("t5_one_stb", 128'(kv_stb), 128'(0));

        // Unmapped port page and undefined offset
        set_rd(NP, 'h00); step();
        chk("t6_bad_port", 128'(reg_rd_resp), 128'(0));
        idle(); set_rd(0, 'h34); step();
        chk("t6_bad_off", 128'(reg_rd_resp), 128'(0));

        // Reset while pending loses the strobe
        idle(); kv_busy = 2'b10; set_wr(1, 'h2c, 32'h0000_0007); step();
        idle(); bus_rst_n = 1'b0; kv_busy = 2'b00; step();
        chk("t6_rst_no_stb", 128'(kv_stb), 128'(0));
        #2 bus_rst_n = 1'b1;
        step();
        chk("t6_after_rst", 128'(kv_stb), 128'(0));

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            reg_rd_req    = ($urandom_range(0, 1) == 1);
            reg_rd_addr   = rand_addr();
            reg_wr_req    = ($urandom_range(0, 4) < 2);
            reg_wr_addr   = rand_addr();
            reg_wr_data   = $urandom;
            chdr_drop_evt = NP'($urandom_range(0, 3) == 0 ? $urandom : 0);
            cpu_drop_evt  = NP'($urandom_range(0, 3) == 0 ? $urandom : 0);
            for (int p = 0; p < NP; p++)
                if ($urandom_range(0, 4) == 0) kv_busy[p] = ~kv_busy[p];
            step();
        end
        idle(); kv_busy = '0; step(); step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
